acq_sequencer: RTL
==================

ACQ_SEQUENCER -- requirements
Module: acq_sequencer

Interface
REQ-001 Parameter MEMORY_ADDR_LEN, default 32, SHALL set the DMA address width.
REQ-002 Parameter CNT_WIDTH, default 16, SHALL set the width of the pre/post length and timeout counters.
REQ-003 clk  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 arm  input  1  SHALL be a one-cycle start pulse (HPS register).
REQ-006 abort  input  1  SHALL be a one-cycle cancel pulse.
REQ-007 continuous  input  1  SHALL select re-arm after ack (1) or single-shot (0).
REQ-008 auto_en  input  1  SHALL enable the auto-trigger timeout.
REQ-009 force_trigger  input  1  SHALL be a one-cycle software trigger.
REQ-010 trigger_in  input  1  SHALL be the level trigger from the trigger-level detector.
REQ-011 in_data_valid  input  1  SHALL qualify one ADC sample per cycle.
REQ-012 in_dma_master_address  input  MEMORY_ADDR_LEN  SHALL be the current DMA write address.
REQ-013 pre_len, post_len, timeout_len  input  CNT_WIDTH each  SHALL give pre-trigger samples, post-trigger samples and auto-trigger clocks.
REQ-014 ack  input  1  SHALL acknowledge completion (HPS register write).
REQ-015 capture_en  output  1  SHALL enable DMA sample writes.
REQ-016 acq_done  output  1  SHALL be a one-cycle completion pulse.
REQ-017 trig_address  output  MEMORY_ADDR_LEN  SHALL hold the DMA address at the trigger.
REQ-018 trig_source  output  2  SHALL hold the trigger source: 1 level, 2 force, 3 auto.
REQ-019 state  output  3  SHALL expose the FSM state: IDLE=0, PRETRIG=1, ARMED=2, POSTTRIG=3, DONE=4.
REQ-020 acq_count  output  16  SHALL count completed acquisitions, wrapping at 0xFFFF->0.

Function
REQ-021 IDLE: on arm, SHALL clear sample_cnt and go to PRETRIG; all other inputs are ignored.
REQ-022 PRETRIG: SHALL increment sample_cnt on in_data_valid and go to ARMED the cycle sample_cnt reaches pre_len; pre_len=0 goes to ARMED after one cycle; triggers are ignored.
REQ-023 ARMED: SHALL trigger on the first of (priority order):
  - trigger_in rising edge (registered previous value; a level already high on entry does not fire);
  - force_trigger;
  - auto_en and timeout_cnt == timeout_len.
REQ-024 timeout_cnt SHALL clear on ARMED entry and increment every clock in ARMED.
REQ-025 On trigger, SHALL register trig_address <= in_dma_master_address and trig_source, clear sample_cnt, and go to POSTTRIG on the next edge.
REQ-026 POSTTRIG: SHALL count in_data_valid and go to DONE when sample_cnt reaches post_len; post_len=0 is treated as 1.
REQ-027 DONE entry SHALL pulse acq_done for exactly one cycle and increment acq_count.
REQ-028 DONE: on ack, SHALL go to PRETRIG if continuous=1, else IDLE; ack in any other state is ignored.
REQ-029 capture_en SHALL equal 1 exactly in PRETRIG, ARMED and POSTTRIG, registered with state.
REQ-030 abort SHALL force IDLE on the next edge from any state, with priority over arm/ack/trigger; trig_address, trig_source and acq_count are retained.
REQ-031 arm outside IDLE SHALL be ignored; length inputs SHALL be sampled live (software holds them stable while capture_en=1).
REQ-032 Counters SHALL saturate, not wrap, at all-ones.

Reset
REQ-033 rst SHALL asynchronously force: state IDLE, capture_en 0, acq_done 0, trig_address 0, trig_source 0, acq_count 0, internal counters 0, previous-trigger register 1 (no false edge after reset).

Structure
REQ-034 State encodings and trig_source codes SHALL live in the shared package acq_pkg.
REQ-035 The trigger-edge/timeout qualification SHALL be one sub-module, acq_trig_qual; the FSM and counters stay in acq_sequencer.

Verification
REQ-036 pre_len=4, post_len=8, trigger_in rises 10 valid samples after arm, address 0x1000_0040 -> trig_address=0x1000_0040, trig_source=1, acq_done 8 valid samples later, capture_en low in DONE.
REQ-037 trigger_in held high through arm and PRETRIG -> no trigger until it falls and rises again.
REQ-038 auto_en=1, timeout_len=100, no trigger -> trig_source=3 after 100 clocks in ARMED; force_trigger in the same cycle as timeout -> trig_source=2.
REQ-039 continuous=1, two ack cycles -> PRETRIG re-entered each time, acq_count=2; continuous=0 -> IDLE.
REQ-040 abort in POSTTRIG, and rst asserted mid-POSTTRIG -> IDLE, capture_en=0, no acq_done; after rst, acq_count=0.
REQ-041 pre_len=0, post_len=0 -> ARMED one cycle after arm; DONE after one valid post-trigger sample.

Source files
------------

// File: rtl/acq_pkg.sv
// Shared types for the acquisition sequencer: FSM state codes and trigger sources.
package acq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PRETRIG  = 3'd1,
        ST_ARMED    = 3'd2,
        ST_POSTTRIG = 3'd3,
        ST_DONE     = 3'd4
    } acq_state_e;

    typedef enum logic [1:0] {
        SRC_NONE  = 2'd0,
        SRC_LEVEL = 2'd1,
        SRC_FORCE = 2'd2,
        SRC_AUTO  = 2'd3
    } trig_src_e;

    function automatic logic capturing(input acq_state_e s);
        return (s == ST_PRETRIG) || (s == ST_ARMED) || (s == ST_POSTTRIG);
    endfunction

endpackage

// File: rtl/acq_trig_qual.sv
// Trigger qualification: level rising edge, software force and auto timeout,
// resolved in that priority order while the sequencer is armed.
module acq_trig_qual
    import acq_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 armed,
    input  logic                 trigger_in,
    input  logic                 force_trigger,
    input  logic                 auto_en,
    input  logic [CNT_WIDTH-1:0] timeout_len,
    output logic                 fire,
    output trig_src_e            src
);

    logic                 prev_trig;
    logic [CNT_WIDTH-1:0] timeout_cnt;
    logic                 rise;
    logic                 timeout_hit;

    // prev_trig resets high so a level already asserted never looks like an edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_trig   <= 1'b1;
            timeout_cnt <= '0;
        end else begin
            prev_trig <= trigger_in;
            if (!armed)
                timeout_cnt <= '0;
            else if (timeout_cnt != '1)
                timeout_cnt <= timeout_cnt + CNT_WIDTH'(1);
        end
    end

    assign rise        = trigger_in & ~prev_trig;
    assign timeout_hit = auto_en && (timeout_cnt == timeout_len);

    always_comb begin
        fire = 1'b0;
        src  = SRC_NONE;
        if (armed) begin
            if (rise) begin
                fire = 1'b1;
                src  = SRC_LEVEL;
            end else if (force_trigger) begin
                fire = 1'b1;
                src  = SRC_FORCE;
            end else if (timeout_hit) begin
                fire = 1'b1;
                src  = SRC_AUTO;
            end
        end
    end

endmodule

// File: rtl/acq_sequencer.sv
// Acquisition sequencer: pre-trigger fill, armed wait, post-trigger capture,
// completion handshake with the HPS, optional continuous re-arm.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int MEMORY_ADDR_LEN = 32,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic                       abort,
    input  logic                       continuous,
    input  logic                       auto_en,
    input  logic                       force_trigger,
    input  logic                       trigger_in,
    input  logic                       in_data_valid,
    input  logic [MEMORY_ADDR_LEN-1:0] in_dma_master_address,
    input  logic [CNT_WIDTH-1:0]       pre_len,
    input  logic [CNT_WIDTH-1:0]       post_len,
    input  logic [CNT_WIDTH-1:0]       timeout_len,
    input  logic                       ack,
    output logic                       capture_en,
    output logic                       acq_done,
    output logic [MEMORY_ADDR_LEN-1:0] trig_address,
    output logic [1:0]                 trig_source,
    output logic [2:0]                 state,
    output logic [15:0]                acq_count
);

    acq_state_e           state_q;
    acq_state_e           next_state;
    logic [CNT_WIDTH-1:0] sample_cnt;
    logic [CNT_WIDTH-1:0] sample_next;
    logic [CNT_WIDTH:0]   cnt_inc;
    logic [CNT_WIDTH-1:0] post_eff;
    logic                 fire;
    trig_src_e            src;
    logic                 trig_load;
    logic                 done_entry;

    acq_trig_qual #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_qual (
        .clk          (clk),
        .rst          (rst),
        .armed        (state_q == ST_ARMED),
        .trigger_in   (trigger_in),
        .force_trigger(force_trigger),
        .auto_en      (auto_en),
        .timeout_len  (timeout_len),
        .fire         (fire),
        .src          (src)
    );

    assign cnt_inc  = {1'b0, sample_cnt} + (CNT_WIDTH + 1)'(1);
    assign post_eff = (post_len == '0) ? CNT_WIDTH'(1) : post_len;

    always_comb begin
        next_state = state_q;
        unique case (state_q)
            ST_IDLE:
                if (arm) next_state = ST_PRETRIG;
            ST_PRETRIG:
                if (pre_len == '0)
                    next_state = ST_ARMED;
                else if (in_data_valid && cnt_inc >= {1'b0, pre_len})
                    next_state = ST_ARMED;
            ST_ARMED:
                if (fire) next_state = ST_POSTTRIG;
            ST_POSTTRIG:
                if (in_data_valid && cnt_inc >= {1'b0, post_eff})
                    next_state = ST_DONE;
            ST_DONE:
                if (ack) next_state = continuous ? ST_PRETRIG : ST_IDLE;
            default:
                next_state = ST_IDLE;
        endcase
        if (abort) next_state = ST_IDLE;

        // every state change restarts the sample count
        sample_next = sample_cnt;
        if (next_state != state_q)
            sample_next = '0;
        else if ((state_q == ST_PRETRIG || state_q == ST_POSTTRIG) &&
                 in_data_valid && sample_cnt != '1)
            sample_next = cnt_inc[CNT_WIDTH-1:0];

        trig_load  = fire && !abort;
        done_entry = (next_state == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            sample_cnt   <= '0;
            capture_en   <= 1'b0;
            acq_done     <= 1'b0;
            trig_address <= '0;
            trig_source  <= 2'd0;
            acq_count    <= 16'd0;
        end else begin
            state_q    <= next_state;
            sample_cnt <= sample_next;
            capture_en <= capturing(next_state);
            acq_done   <= done_entry;
            if (done_entry)
                acq_count <= acq_count + 16'd1;
            if (trig_load) begin
                trig_address <= in_dma_master_address;
                trig_source  <= src;
            end
        end
    end

    assign state = state_q;

endmodule
